// File: rtl/enkel_loader_pkg.sv
// enkel_loader_pkg: shared definitions for the boot-time program loader.
//   - state_t    : loader FSM states
//   - ADDR_W_DEF : default program RAM address width
//   - DATA_W_DEF : default byte / checksum width
//   - chk_add    : modular checksum accumulate (caller truncates to width)
package enkel_loader_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [3:0] {
      S_LEN, S_DATA, S_WSETUP, S_WSTROBE, S_WHOLD,
      S_SUM, S_ARM, S_START, S_RUN, S_ERR
   } state_t;

   // Width-agnostic add; the caller casts the result down to its checksum
   // width, which gives the mod 2^DATA_W wrap for free.
   function automatic logic [31:0] chk_add(input logic [31:0] sum, input logic [31:0] b);
      return sum + b;
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream handshake plus program RAM write bus.
//   in_data/in_valid/in_ready : host -> loader byte stream (valid/ready)
//   ld_addr/ld_data           : RAM write address / data
//   ld_cs_/ld_we_             : RAM chip select / write enable, active low
// master = host/RAM side, slave = loader.
interface program_loader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_cs_;
   logic              ld_we_;

   modport master (output in_data, in_valid,
                   input  in_ready, ld_addr, ld_data, ld_cs_, ld_we_);
   modport slave  (input  in_data, in_valid,
                   output in_ready, ld_addr, ld_data, ld_cs_, ld_we_);
endinterface

// File: rtl/mem_write_strobe.sv
// mem_write_strobe: three-cycle SRAM write strobe sequencer.
//   go    : start a write (one cycle); SETUP begins on the next cycle
//   abort : drop any write in progress, strobes high on the next edge
//   done  : high during the HOLD cycle
//   cs_   : chip select, low for SETUP/STROBE/HOLD
//   we_   : write enable, low only during STROBE
// Address/data stability is the caller's job; this block only sequences
// the strobes so we_ can never be low while cs_ is high.
module mem_write_strobe (
   input  logic clk,
   input  logic reset_,
   input  logic go,
   input  logic abort,
   output logic done,
   output logic cs_,
   output logic we_
);
   typedef enum logic [1:0] {P_IDLE, P_SETUP, P_STROBE, P_HOLD} phase_t;
   phase_t ph;

   always_ff @(posedge clk) begin
      if (!reset_ || abort) begin
         ph   <= P_IDLE;
         cs_  <= 1'b1;
         we_  <= 1'b1;
         done <= 1'b0;
      end else begin
         case (ph)
            P_IDLE:   if (go) begin ph <= P_SETUP; cs_ <= 1'b0; end
            P_SETUP:  begin ph <= P_STROBE; we_ <= 1'b0; end
            P_STROBE: begin ph <= P_HOLD; we_ <= 1'b1; done <= 1'b1; end
            P_HOLD:   begin ph <= P_IDLE; cs_ <= 1'b1; done <= 1'b0; end
            default:  ph <= P_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed, checksummed byte stream into
// program RAM from address 0, then starts the CPU on a good checksum.
//   clk, reset_     : clock, synchronous active-low reset
//   halt            : abort, back to waiting for LEN
//   bus (slave)     : byte stream in, RAM write strobes out
//   turn_ON         : holds CPU start flops in reset while high
//   start_computer  : one-cycle start pulse
//   status          : CPU run enable
//   err             : checksum failure, sticky until halt
// Frame: LEN, N data bytes, CHK; LEN = 0 means 2^ADDR_W words. Good when
// LEN + data + CHK == 0 mod 2^DATA_W. All outputs are flops loaded from the
// next state, so they line up with the state they describe.
module program_loader
   import enkel_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             halt,
   program_loader_if.slave  bus,
   output logic             turn_ON,
   output logic             start_computer,
   output logic             status,
   output logic             err
);
   localparam logic [ADDR_W:0] FULL_N = {1'b1, {ADDR_W{1'b0}}};

   state_t            state, nxt;
   logic              in_ready_q;
   logic [ADDR_W-1:0] ld_addr_q;
   logic [DATA_W-1:0] ld_data_q, sum_q, sum_nx;
   // One bit wider than the address so a full 2^ADDR_W frame never wraps.
   logic [ADDR_W:0]   n_q, cnt_q, cnt_inc, len_n;
   logic              xfer, wr_go, wr_done, cs_w, we_w;

   assign xfer    = bus.in_valid & in_ready_q;
   assign cnt_inc = cnt_q + 1'b1;
   assign sum_nx  = DATA_W'(chk_add(32'(sum_q), 32'(bus.in_data)));
   assign wr_go   = (state == S_DATA) & xfer & ~halt;

   // LEN = 0 means a full memory; oversize LEN is clamped to a full memory.
   always_comb begin
      len_n = FULL_N;
      if (bus.in_data != '0 && 32'(bus.in_data) <= 32'(FULL_N))
         len_n = bus.in_data[ADDR_W:0];
   end

   always_comb begin
      nxt = state;
      if (halt) nxt = S_LEN;
      else begin
         case (state)
            S_LEN:     if (xfer) nxt = S_DATA;
            S_DATA:    if (xfer) nxt = S_WSETUP;
            S_WSETUP:  nxt = S_WSTROBE;
            S_WSTROBE: nxt = S_WHOLD;
            S_WHOLD:   if (wr_done) nxt = (cnt_inc == n_q) ? S_SUM : S_DATA;
            S_SUM:     if (xfer) nxt = (sum_nx == '0) ? S_ARM : S_ERR;
            S_ARM:     nxt = S_START;
            S_START:   nxt = S_RUN;
            S_RUN:     nxt = S_RUN;
            S_ERR:     nxt = S_ERR;
            default:   nxt = S_LEN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state          <= S_LEN;
         in_ready_q     <= 1'b0;
         ld_addr_q      <= '0;
         ld_data_q      <= '0;
         sum_q          <= '0;
         n_q            <= '0;
         cnt_q          <= '0;
         turn_ON        <= 1'b1;
         start_computer <= 1'b0;
         status         <= 1'b0;
         err            <= 1'b0;
      end else begin
         state          <= nxt;
         in_ready_q     <= (nxt == S_LEN) || (nxt == S_DATA) || (nxt == S_SUM);
         turn_ON        <= !((nxt == S_ARM) || (nxt == S_START) || (nxt == S_RUN));
         start_computer <= (nxt == S_START);
         status         <= (nxt == S_START) || (nxt == S_RUN);
         err            <= (nxt == S_ERR);
         if (!halt) begin
            case (state)
               S_LEN: if (xfer) begin
                  n_q       <= len_n;
                  sum_q     <= bus.in_data;
                  cnt_q     <= '0;
                  ld_addr_q <= '0;
               end
               S_DATA: if (xfer) begin
                  ld_data_q <= bus.in_data;
                  sum_q     <= sum_nx;
               end
               // Address moves only after HOLD, keeping it stable for the strobe.
               S_WHOLD: if (wr_done) begin
                  cnt_q     <= cnt_inc;
                  ld_addr_q <= cnt_inc[ADDR_W-1:0];
               end
               default: ;
            endcase
         end
      end
   end

   mem_write_strobe u_strobe (
      .clk    (clk),
      .reset_ (reset_),
      .go     (wr_go),
      .abort  (halt),
      .done   (wr_done),
      .cs_    (cs_w),
      .we_    (we_w)
   );

   assign bus.in_ready = in_ready_q;
   assign bus.ld_addr  = ld_addr_q;
   assign bus.ld_data  = ld_data_q;
   assign bus.ld_cs_   = cs_w;
   assign bus.ld_we_   = we_w;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven frames, hand sequences for halt/reset
// corner cases, and random frames checked against a checksum/write model.
module tb_program_loader;
   localparam int AW = 5, DW = 8, WORDS = 32;

   logic clk = 1'b0, reset_ = 1'b0, halt = 1'b0;
   logic turn_ON, start_computer, status, err;

   program_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_(reset_), .halt(halt), .bus(bus),
      .turn_ON(turn_ON), .start_computer(start_computer),
      .status(status), .err(err)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [7:0] len, base, step;
      bit zero_chk, gaps, exp_err;
      int exp_n;
   } vec_t;

   int n_chk = 0, n_fail = 0, cyc = 0, viol = 0;
   int xfer_q[$], start_q[$];
   logic [15:0] wr_q[$];
   logic prev_we = 1'b1, prev_st = 1'b0;

   // Passive monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (bus.in_valid && bus.in_ready) xfer_q.push_back(cyc);
      if (!bus.ld_we_) wr_q.push_back({3'b000, bus.ld_addr, bus.ld_data});
      if (start_computer) start_q.push_back(cyc);
      if ((!bus.ld_we_ && bus.ld_cs_) || (!bus.ld_we_ && !prev_we) || (start_computer && prev_st))
         viol++;
      prev_we = bus.ld_we_;
      prev_st = start_computer;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic bit frame_ok(input logic [7:0] len, input bq_t d, input logic [7:0] chk);
      int s = int'(len) + int'(chk);
      foreach (d[i]) s += int'(d[i]);
      return (s % 256) == 0;
   endfunction

   function automatic logic [7:0] good_chk(input logic [7:0] len, input bq_t d);
      int s = int'(len);
      foreach (d[i]) s += int'(d[i]);
      return 8'((256 - (s % 256)) % 256);
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Called aligned just after a rising edge; returns just after the edge
   // on which the byte was transferred, with in_valid still high.
   task automatic send(input logic [7:0] b, input bit gaps);
      int n = 0;
      if (gaps) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) step();
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 64);
      if (!bus.in_ready) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", n);
      end
      step();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".in_ready"}, bus.in_ready, 0);
      check({tag, ".ld_addr"},  bus.ld_addr,  0);
      check({tag, ".ld_data"},  bus.ld_data,  0);
      check({tag, ".cs_"},      bus.ld_cs_,   1);
      check({tag, ".we_"},      bus.ld_we_,   1);
      check({tag, ".turn_ON"},  turn_ON,      1);
      check({tag, ".start"},    start_computer, 0);
      check({tag, ".status"},   status,       0);
      check({tag, ".err"},      err,          0);
   endtask

   task automatic pulse_halt(input string tag);
      step();
      bus.in_valid = 1'b0;
      halt = 1'b1;
      step();
      halt = 1'b0;
      @(negedge clk);
      check({tag, ".halt_err"},    err,          0);
      check({tag, ".halt_status"}, status,       0);
      check({tag, ".halt_turnon"}, turn_ON,      1);
      check({tag, ".halt_ready"},  bus.in_ready, 1);
      check({tag, ".halt_cs"},     bus.ld_cs_,   1);
      step();
   endtask

   task automatic run_frame(input logic [7:0] len, input bq_t d, input logic [7:0] chk,
                            input bit gaps, input bit exp_err, input int exp_n, input string tag);
      int ir = 0;
      int m;
      wr_q.delete(); xfer_q.delete(); start_q.delete();
      send(len, gaps);
      foreach (d[i]) send(d[i], gaps);
      send(chk, gaps);
      // One cycle after the CHK transfer.
      @(negedge clk);
      check({tag, ".turnon_t1"}, turn_ON, exp_err);
      check({tag, ".err_t1"},    err,     exp_err);
      check({tag, ".start_t1"},  start_computer, 0);
      @(negedge clk);
      check({tag, ".start_t2"},  start_computer, !exp_err);
      check({tag, ".status_t2"}, status,  !exp_err);
      // in_valid is still high: RUN/ERR must ignore the stream.
      repeat (6) begin
         @(negedge clk);
         if (bus.in_ready) ir++;
      end
      check({tag, ".ready_ignored"}, ir, 0);
      check({tag, ".status_end"},  status,  !exp_err);
      check({tag, ".err_end"},     err,     exp_err);
      check({tag, ".turnon_end"},  turn_ON, exp_err);
      check({tag, ".n_starts"},    start_q.size(), exp_err ? 0 : 1);
      if (!exp_err && start_q.size() == 1 && xfer_q.size() > 0)
         check({tag, ".start_lat"}, start_q[0] - xfer_q[xfer_q.size()-1], 2);
      check({tag, ".n_writes"}, wr_q.size(), exp_n);
      m = (wr_q.size() < exp_n) ? wr_q.size() : exp_n;
      for (int i = 0; i < m; i++)
         check($sformatf("%s.wr%0d", tag, i), wr_q[i], {3'b000, i[4:0], d[i]});
      if (!gaps && xfer_q.size() == exp_n + 2)
         for (int k = 0; k <= exp_n; k++)
            check($sformatf("%s.gap%0d", tag, k), xfer_q[k+1] - xfer_q[k], (k == 0) ? 1 : 4);
      pulse_halt(tag);
   endtask

   initial begin
      vec_t tbl[5];
      bq_t  d;
      logic [7:0] chk, len;
      bit   good;
      int   n;

      tbl[0] = '{len:8'h03, base:8'h11, step:8'h11, zero_chk:0, gaps:0, exp_err:0, exp_n:3};
      tbl[1] = '{len:8'h03, base:8'h11, step:8'h11, zero_chk:1, gaps:0, exp_err:1, exp_n:3};
      tbl[2] = '{len:8'h00, base:8'h00, step:8'h01, zero_chk:0, gaps:0, exp_err:0, exp_n:32};
      tbl[3] = '{len:8'h01, base:8'hA5, step:8'h00, zero_chk:0, gaps:1, exp_err:0, exp_n:1};
      tbl[4] = '{len:8'h05, base:8'h80, step:8'h07, zero_chk:1, gaps:1, exp_err:1, exp_n:5};

      bus.in_data = '0; bus.in_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check_reset_vals("por");
      step();
      reset_ = 1'b1;
      step();
      @(negedge clk);
      check("ready_after_reset", bus.in_ready, 1);
      step();

      // Table-driven frames.
      for (int v = 0; v < 5; v++) begin
         d.delete();
         for (int i = 0; i < tbl[v].exp_n; i++)
            d.push_back(8'(int'(tbl[v].base) + int'(tbl[v].step) * i));
         chk = tbl[v].zero_chk ? 8'h00 : good_chk(tbl[v].len, d);
         run_frame(tbl[v].len, d, chk, tbl[v].gaps, tbl[v].exp_err, tbl[v].exp_n,
                   $sformatf("tbl%0d", v));
      end

      // Halt during the write strobe.
      send(8'd4, 0);
      send(8'hAB, 0);
      bus.in_valid = 1'b0;
      step();
      @(negedge clk);
      check("hw.we_low", bus.ld_we_, 0);
      check("hw.cs_low", bus.ld_cs_, 0);
      halt = 1'b1;
      step();
      halt = 1'b0;
      @(negedge clk);
      check("hw.cs_", bus.ld_cs_, 1);
      check("hw.we_", bus.ld_we_, 1);
      check("hw.ready", bus.in_ready, 1);
      check("hw.status", status, 0);
      step();
      d.delete(); d.push_back(8'h5A); d.push_back(8'hC3);
      run_frame(8'd2, d, good_chk(8'd2, d), 0, 0, 2, "hw_next");

      // Reset while waiting for a data byte.
      send(8'd5, 0);
      send(8'h3C, 0);
      send(8'h4D, 0);
      bus.in_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("rm.addr_pre", bus.ld_addr, 2);
      check("rm.data_pre", bus.ld_data, 8'h4D);
      check("rm.ready_pre", bus.in_ready, 1);
      reset_ = 1'b0;
      @(negedge clk);
      check_reset_vals("rm");
      step();
      reset_ = 1'b1;
      step();

      // Reset during write setup.
      send(8'd2, 0);
      send(8'h77, 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rw.cs_low", bus.ld_cs_, 0);
      reset_ = 1'b0;
      @(negedge clk);
      check("rw.cs_", bus.ld_cs_, 1);
      check("rw.we_", bus.ld_we_, 1);
      step();
      reset_ = 1'b1;
      step();
      d.delete(); d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
      run_frame(8'h03, d, 8'h97, 0, 0, 3, "rw_next");

      // Random frames against the model.
      for (int r = 0; r < 8; r++) begin
         len = 8'($urandom_range(0, WORDS));
         n = (len == 0) ? WORDS : int'(len);
         d.delete();
         for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
         good = ($urandom_range(0, 3) != 0);
         chk = good_chk(len, d);
         if (!good) chk = chk + 8'($urandom_range(1, 255));
         run_frame(len, d, chk, 1'($urandom_range(0, 1)), !frame_ok(len, d, chk), n,
                   $sformatf("rnd%0d", r));
      end

      check("strobe_protocol_violations", viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
